mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage that sits directly after the execute stage and consumes its registered outputs: ex_result_bus, s_reg_write_bus and s_mem_contral_bus.
- Performs loads and stores against a data memory port with a req/ack handshake. Multi-cycle accesses stall the pipeline by deasserting PIPELINE_VALID.
- Aligns and extends load data, then presents the writeback result.
- Supplies the forwarding value that the execute stage consumes on its d_rs_fastforward/d_rt_fastforward inputs.

Parameters:
- REG_WRITE_BUS_LENGTH, 6: bit0 = reg write enable, [5:1] = destination register.
- MEM_CONTRAL_BUS_LENGTH, 5: bit0 = read, bit1 = write, [3:2] = size (00 byte, 01 half, 10 word, 11 reserved, treated as word), bit4 = unsigned load.
- EX_RESULT_BUS_LENGTH, 64: [31:0] = ALU result / address, [63:32] = rt bypass (store data).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- PIPELINE_FLUSH  in  1  squash the instruction being latched.
- PIPELINE_READY  in  1  global advance; the stage latches its inputs on this.
- PIPELINE_VALID  out  1  low while a memory access is outstanding.
- s_reg_write_bus_i  in  REG_WRITE_BUS_LENGTH  from execute.
- s_mem_contral_bus_i  in  MEM_CONTRAL_BUS_LENGTH  from execute.
- ex_result_bus_i  in  EX_RESULT_BUS_LENGTH  from execute.
- dmem_req  out  1  request; held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address, bits [1:0] = 0.
- dmem_wstrb  out  4  byte enables, little-endian lanes.
- dmem_wdata  out  32  store data replicated across lanes.
- dmem_ack  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata  in  32  read data.
- s_reg_write_bus  out  REG_WRITE_BUS_LENGTH  to writeback.
- wb_data  out  32  writeback value.
- s_addr_error  out  1  misaligned access flag, to writeback.
- fwd_data  out  32  equals wb_data.
- fwd_load_pending  out  1  a load is in this stage and its data is not yet available; the hazard unit must stall.

Behaviour:
- Input registers: all inputs latch when PIPELINE_READY=1.
- Flush: if PIPELINE_FLUSH=1 and PIPELINE_READY=1, the control registers (s_reg_write_bus, mem control, state) load 0. The data registers latch regardless. PIPELINE_FLUSH without PIPELINE_READY is ignored.
- Reset: rst_n=0 at a clock edge forces:
  - state IDLE,
  - s_reg_write_bus=0, mem control=0, s_addr_error=0,
  - load data register=0, result register=0.
  - Resulting outputs: PIPELINE_VALID=1, dmem_req=0, wb_data=0.
- FSM states: IDLE, ACCESS, DONE.
  - On latch with a memory op (read or write) and aligned address: next state ACCESS.
  - On latch with a non-memory op or a misaligned address: next state IDLE.
  - ACCESS: dmem_req=1, PIPELINE_VALID=0. dmem_addr, dmem_we, dmem_wstrb and dmem_wdata are held stable.
  - ACCESS with dmem_ack=1 at a clock edge: capture dmem_rdata, next state DONE.
  - DONE: PIPELINE_VALID=1, dmem_req=0. DONE is held until PIPELINE_READY, which latches the next instruction.
  - IDLE: PIPELINE_VALID=1, dmem_req=0.
  - Minimum latency: one stall cycle (ack in the first ACCESS cycle).
- Alignment: a half access with addr[0]=1 is misaligned. A word access with addr[1:0]≠0 is misaligned. A misaligned access issues no request, sets s_addr_error=1 and clears the write enable in s_reg_write_bus.
- Store strobes:
  - byte: wstrb = 1<<addr[1:0], wdata = {4{rt[7:0]}}.
  - half: wstrb = 0011 or 1100, wdata = {2{rt[15:0]}}.
  - word: wstrb = 1111, wdata = rt.
- Load extraction: select the lane by addr[1:0] from the captured rdata, then sign- or zero-extend according to bit4.
- wb_data: extracted load data when the latched op is a read; otherwise ex_result[31:0] (combinational from registers).
- fwd_load_pending: 1 in ACCESS when the latched op is a read; else 0.
- A store never writes a register. If the execute stage sets write enable on a store, it passes through unmodified.
- Reset while in ACCESS: drop the request immediately. The memory must tolerate an abandoned request.
- An ack in IDLE or DONE is ignored.

Test Plan:
- ALU op, no memory: s_mem_contral_bus_i=0, ex_result=0x0000_1234, write to r8 -> next cycle PIPELINE_VALID=1, wb_data=0x1234, s_reg_write_bus={r8,1}, dmem_req=0.
- lw from 0x100, ack delayed 3 cycles with rdata=0xDEADBEEF -> dmem_addr=0x100, req high for 3 cycles, VALID=0 and fwd_load_pending=1 during ACCESS, then VALID=1 and wb_data=0xDEADBEEF.
- lb from 0x103 and lbu from 0x103, rdata=0x80AABBCC, ack immediate -> wb_data=0xFFFFFF80 (lb) and 0x00000080 (lbu).
- sh of rt=0x0000ABCD to 0x202 -> dmem_we=1, addr=0x200, wstrb=1100, wdata=0xABCDABCD.
- lw from 0x101 -> no req, s_addr_error=1, write enable cleared, VALID stays 1.
- Flush with READY during latch of an sw -> no request issued, s_reg_write_bus=0. rst_n=0 in the middle of an ACCESS -> req=0 on the next cycle, VALID=1.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: load/store over a req/ack data port, load align/extend, writeback and forwarding.
module mem_stage #(
  parameter int REG_WRITE_BUS_LENGTH   = 6,
  parameter int MEM_CONTRAL_BUS_LENGTH = 5,
  parameter int EX_RESULT_BUS_LENGTH   = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              PIPELINE_FLUSH,
  input  logic                              PIPELINE_READY,
  output logic                              PIPELINE_VALID,
  input  logic [REG_WRITE_BUS_LENGTH-1:0]   s_reg_write_bus_i,
  input  logic [MEM_CONTRAL_BUS_LENGTH-1:0] s_mem_contral_bus_i,
  input  logic [EX_RESULT_BUS_LENGTH-1:0]   ex_result_bus_i,
  output logic                              dmem_req,
  output logic                              dmem_we,
  output logic [31:0]                       dmem_addr,
  output logic [3:0]                        dmem_wstrb,
  output logic [31:0]                       dmem_wdata,
  input  logic                              dmem_ack,
  input  logic [31:0]                       dmem_rdata,
  output logic [REG_WRITE_BUS_LENGTH-1:0]   s_reg_write_bus,
  output logic [31:0]                       wb_data,
  output logic                              s_addr_error,
  output logic [31:0]                       fwd_data,
  output logic                              fwd_load_pending
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                            state;
  logic [MEM_CONTRAL_BUS_LENGTH-1:0] mem_ctl_q;
  logic [EX_RESULT_BUS_LENGTH-1:0]   ex_result_q;
  logic [31:0]                       load_data_q;
  logic                              addr_err_q;

  logic       in_mem;
  logic [1:0] in_size;
  logic [1:0] in_lane;
  logic       in_misaligned;
  logic       latch;

  assign in_mem  = s_mem_contral_bus_i[0] | s_mem_contral_bus_i[1];
  assign in_size = s_mem_contral_bus_i[3:2];
  assign in_lane = ex_result_bus_i[1:0];
  // Size 11 is treated as a word access for alignment purposes.
  assign in_misaligned = in_mem &&
                         (((in_size == 2'b01) && in_lane[0]) ||
                          (in_size[1] && (in_lane != 2'b00)));
  // Address and store data must stay stable while the access is outstanding.
  assign latch = PIPELINE_READY && (state != ACCESS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      s_reg_write_bus <= '0;
      mem_ctl_q       <= '0;
      addr_err_q      <= 1'b0;
      load_data_q     <= '0;
      ex_result_q     <= '0;
    end else if (latch) begin
      ex_result_q <= ex_result_bus_i;
      if (PIPELINE_FLUSH) begin
        state           <= IDLE;
        s_reg_write_bus <= '0;
        mem_ctl_q       <= '0;
        addr_err_q      <= 1'b0;
      end else begin
        mem_ctl_q       <= s_mem_contral_bus_i;
        addr_err_q      <= in_misaligned;
        s_reg_write_bus <= in_misaligned ?
                           {s_reg_write_bus_i[REG_WRITE_BUS_LENGTH-1:1], 1'b0} :
                           s_reg_write_bus_i;
        state           <= (in_mem && !in_misaligned) ? ACCESS : IDLE;
      end
    end else if ((state == ACCESS) && dmem_ack) begin
      load_data_q <= dmem_rdata;
      state       <= DONE;
    end
  end

  logic [1:0]  lane;
  logic [1:0]  size;
  logic [31:0] rt;
  logic [31:0] shifted;
  logic [3:0]  strb;
  logic [31:0] load_ext;

  assign lane    = ex_result_q[1:0];
  assign size    = mem_ctl_q[3:2];
  assign rt      = ex_result_q[63:32];
  assign shifted = load_data_q >> {lane, 3'b000};

  always_comb begin
    strb       = 4'b1111;
    dmem_wdata = rt;
    load_ext   = load_data_q;
    case (size)
      2'b00: begin
        strb       = 4'b0001 << lane;
        dmem_wdata = {4{rt[7:0]}};
        load_ext   = mem_ctl_q[4] ? {24'h0, shifted[7:0]} :
                                    {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        strb       = lane[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{rt[15:0]}};
        load_ext   = mem_ctl_q[4] ? {16'h0, shifted[15:0]} :
                                    {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        strb       = 4'b1111;
        dmem_wdata = rt;
        load_ext   = load_data_q;
      end
    endcase
  end

  assign PIPELINE_VALID   = (state != ACCESS);
  assign dmem_req         = (state == ACCESS);
  assign dmem_we          = mem_ctl_q[1];
  assign dmem_addr        = {ex_result_q[31:2], 2'b00};
  assign dmem_wstrb       = mem_ctl_q[1] ? strb : 4'b0000;
  assign wb_data          = mem_ctl_q[0] ? load_ext : ex_result_q[31:0];
  assign fwd_data         = wb_data;
  assign s_addr_error     = addr_err_q;
  assign fwd_load_pending = (state == ACCESS) && mem_ctl_q[0];

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [5:0]  rw_i;
  logic [4:0]  mc_i;
  logic [63:0] ex_i;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic [5:0]  rw_o;
  logic [31:0] wb;
  logic        err;
  logic [31:0] fwd;
  logic        pend;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] wb;
    logic [5:0]  rw;
    logic        err;
    bit          chk_wb;
  } exp_t;

  exp_t sb[$];

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .PIPELINE_FLUSH(flush), .PIPELINE_READY(ready), .PIPELINE_VALID(valid),
    .s_reg_write_bus_i(rw_i), .s_mem_contral_bus_i(mc_i), .ex_result_bus_i(ex_i),
    .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wstrb(wstrb),
    .dmem_wdata(wdata), .dmem_ack(ack), .dmem_rdata(rdata),
    .s_reg_write_bus(rw_o), .wb_data(wb), .s_addr_error(err),
    .fwd_data(fwd), .fwd_load_pending(pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] w, input logic [5:0] r,
                      input logic e, input bit cw);
    exp_t x;
    x.tag = tag; x.wb = w; x.rw = r; x.err = e; x.chk_wb = cw;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      chk({x.tag, "_valid"}, valid, 1);
      chk({x.tag, "_rw"}, rw_o, x.rw);
      chk({x.tag, "_err"}, err, x.err);
      chk({x.tag, "_req"}, req, 0);
      if (x.chk_wb) begin
        chk({x.tag, "_wb"}, wb, x.wb);
        chk({x.tag, "_fwd"}, fwd, x.wb);
      end
    end
  endtask

  task automatic issue(input logic [5:0] r, input logic [4:0] m, input logic [63:0] e,
                       input logic fl);
    rw_i = r; mc_i = m; ex_i = e; flush = fl; ready = 1'b1;
    step();
    ready = 1'b0; flush = 1'b0;
  endtask

  // Ack is raised during the n-th ACCESS cycle; each stall cycle is checked on the way.
  task automatic serve(input string tag, input int n, input logic [31:0] rd, input logic is_load);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (!req) break;
      seen++;
      chk({tag, "_stall_valid"}, valid, 0);
      chk({tag, "_pend"}, pend, is_load);
      if (i == n - 1) begin
        ack = 1'b1;
        rdata = rd;
      end
      step();
      ack = 1'b0;
    end
    chk({tag, "_req_cycles"}, seen, n);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
    rw_i = '0; mc_i = '0; ex_i = '0; ack = 1'b0; rdata = '0;
    repeat (2) step();
    chk("rst_valid", valid, 1);
    chk("rst_req", req, 0);
    chk("rst_wb", wb, 0);
    chk("rst_rw", rw_o, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // ALU result passes straight through
    issue(6'h11, 5'h00, 64'h0000_0000_0000_1234, 1'b0);
    push("alu", 32'h1234, 6'h11, 1'b0, 1'b1);
    pop_check();

    // lw with ack in the third ACCESS cycle
    issue(6'h0B, 5'h09, 64'h0000_0000_0000_0100, 1'b0);
    push("lw", 32'hDEAD_BEEF, 6'h0B, 1'b0, 1'b1);
    chk("lw_addr", addr, 32'h100);
    chk("lw_we", we, 0);
    serve("lw", 3, 32'hDEAD_BEEF, 1'b1);
    pop_check();

    // DONE holds its result and ignores a stray ack
    ack = 1'b1; rdata = 32'h1111_1111;
    step();
    ack = 1'b0;
    chk("done_hold_wb", wb, 32'hDEAD_BEEF);
    chk("done_hold_valid", valid, 1);

    issue(6'h0B, 5'h01, 64'h0000_0000_0000_0103, 1'b0);
    push("lb", 32'hFFFF_FF80, 6'h0B, 1'b0, 1'b1);
    serve("lb", 1, 32'h80AA_BBCC, 1'b1);
    pop_check();

    issue(6'h0B, 5'h11, 64'h0000_0000_0000_0103, 1'b0);
    push("lbu", 32'h0000_0080, 6'h0B, 1'b0, 1'b1);
    serve("lbu", 1, 32'h80AA_BBCC, 1'b1);
    pop_check();

    issue(6'h0D, 5'h05, 64'h0000_0000_0000_0102, 1'b0);
    push("lh", 32'hFFFF_80AA, 6'h0D, 1'b0, 1'b1);
    serve("lh", 1, 32'h80AA_BBCC, 1'b1);
    pop_check();

    issue(6'h0D, 5'h15, 64'h0000_0000_0000_0100, 1'b0);
    push("lhu", 32'h0000_BBCC, 6'h0D, 1'b0, 1'b1);
    serve("lhu", 1, 32'h80AA_BBCC, 1'b1);
    pop_check();

    // sh to the upper half
    issue(6'h00, 5'h06, 64'h0000_ABCD_0000_0202, 1'b0);
    push("sh", 32'h0000_0202, 6'h00, 1'b0, 1'b1);
    chk("sh_we", we, 1);
    chk("sh_addr", addr, 32'h200);
    chk("sh_wstrb", wstrb, 4'b1100);
    chk("sh_wdata", wdata, 32'hABCD_ABCD);
    serve("sh", 2, 32'h0, 1'b0);
    pop_check();

    issue(6'h00, 5'h02, 64'h0000_0055_0000_0101, 1'b0);
    push("sb", 32'h0000_0101, 6'h00, 1'b0, 1'b1);
    chk("sb_addr", addr, 32'h100);
    chk("sb_wstrb", wstrb, 4'b0010);
    chk("sb_wdata", wdata, 32'h5555_5555);
    serve("sb", 1, 32'h0, 1'b0);
    pop_check();

    issue(6'h00, 5'h0A, 64'h1234_5678_0000_0104, 1'b0);
    push("sw", 32'h0000_0104, 6'h00, 1'b0, 1'b1);
    chk("sw_wstrb", wstrb, 4'b1111);
    chk("sw_wdata", wdata, 32'h1234_5678);
    serve("sw", 1, 32'h0, 1'b0);
    pop_check();

    // misaligned word and half loads: no request, write enable cleared
    issue(6'h0F, 5'h09, 64'h0000_0000_0000_0101, 1'b0);
    push("lw_mis", 32'h0, 6'h0E, 1'b1, 1'b0);
    pop_check();
    step();
    chk("lw_mis_req_later", req, 0);

    issue(6'h13, 5'h05, 64'h0000_0000_0000_0103, 1'b0);
    push("lh_mis", 32'h0, 6'h12, 1'b1, 1'b0);
    pop_check();

    // flushed store: data latched, control cleared, no request
    issue(6'h03, 5'h0A, 64'h1234_5678_0000_0300, 1'b1);
    push("flush", 32'h0000_0300, 6'h00, 1'b0, 1'b1);
    pop_check();
    step();
    chk("flush_req_later", req, 0);

    // flush without ready is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_noready_wb", wb, 32'h300);

    // reset in the middle of an access
    issue(6'h0B, 5'h09, 64'h0000_0000_0000_0100, 1'b0);
    chk("rstmid_req_before", req, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstmid_req", req, 0);
    chk("rstmid_valid", valid, 1);
    chk("rstmid_wb", wb, 0);
    chk("rstmid_pend", pend, 0);

    // ack while idle has no effect
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    step();
    ack = 1'b0;
    chk("idle_ack_valid", valid, 1);
    chk("idle_ack_req", req, 0);
    chk("idle_ack_wb", wb, 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
